// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and width helpers for the packet round-robin
// arbiter that fronts a fifo's write side.
//   arb_state_e  : arbiter FSM states (IDLE between packets, LOCK while a
//                  producer owns the fifo)
//   id_width()   : bits needed for a requester index (at least 1)
//   cnt_width()  : bits needed for a beat counter that reaches max_beats-1
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Sized for max_beats+1 so max_beats==1 still yields a 1-bit counter.
    function automatic int cnt_width(input int max_beats);
        return $clog2(max_beats + 1);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req_i  : request vector, one bit per requester
//   ptr_i  : index of the most recent winner (lowest priority this round)
//   pick_o : first requesting index scanning upward from ptr_i+1, wrapping
//   any_o  : at least one request present (pick_o is valid)
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     pick_o,
    output logic               any_o
);

    always_comb begin
        int idx;
        idx    = 0;
        pick_o = '0;
        any_o  = 1'b0;
        // k runs 1..NUM_REQ so the previous winner is examined last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!any_o && req_i[idx]) begin
                any_o  = 1'b1;
                pick_o = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: shares one fifo write port among num_req_p packet
// producers. A producer is granted round-robin per packet and keeps the fifo
// until its last beat (or the max_beats_p-th beat) is accepted.
//   clk_i, reset_i : clock, synchronous active-high reset
//   valid_i/data_i/last_i/ready_o : per-requester beat handshake
//   valid_o/data_o/last_o/ready_i : towards the fifo write side
//   grant_id_o : current / most recent owner
//   busy_o     : a packet is in progress (LOCK)
//   trunc_o    : sticky, some packet was force-ended at max_beats_p
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int width_p     = 8,
    parameter int num_req_p   = 4,
    parameter int max_beats_p = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           valid_i,
    input  logic [num_req_p*width_p-1:0]   data_i,
    input  logic [num_req_p-1:0]           last_i,
    output logic [num_req_p-1:0]           ready_o,
    output logic                           valid_o,
    output logic [width_p-1:0]             data_o,
    output logic                           last_o,
    input  logic                           ready_i,
    output logic [$clog2(num_req_p)-1:0]   grant_id_o,
    output logic                           busy_o,
    output logic                           trunc_o
);

    localparam int IdW  = id_width(num_req_p);
    localparam int CntW = cnt_width(max_beats_p);
    localparam logic [CntW-1:0] LastCnt = CntW'(max_beats_p - 1);

    arb_state_e     state_q, state_d;
    logic [IdW-1:0] gnt_q, gnt_d;
    logic [IdW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic           trunc_q, trunc_d;

    logic [width_p-1:0] beat_data [num_req_p];
    for (genvar r = 0; r < num_req_p; r++) begin : g_unpack
        assign beat_data[r] = data_i[r*width_p +: width_p];
    end

    logic [IdW-1:0] pick;
    logic           any_req;

    rr_pick #(
        .NUM_REQ (num_req_p),
        .IDW     (IdW)
    ) u_pick (
        .req_i  (valid_i),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (any_req)
    );

    logic sel_valid, sel_last, at_max, pkt_end, beat_acc;
    assign sel_valid = valid_i[gnt_q];
    assign sel_last  = last_i[gnt_q];
    assign at_max    = (cnt_q == LastCnt);
    // The beat at the length cap ends the packet whether or not it is flagged.
    assign pkt_end   = sel_last | at_max;
    assign beat_acc  = (state_q == LOCK) & sel_valid & ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= IdW'(num_req_p - 1);
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = LOCK;
                    gnt_d   = pick;
                    ptr_d   = pick;
                    cnt_d   = '0;
                end
            end
            LOCK: begin
                if (beat_acc) begin
                    if (pkt_end) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (at_max && !sel_last) trunc_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: data path is a pure mux on the registered grant.
    always_comb begin
        valid_o = 1'b0;
        last_o  = 1'b0;
        ready_o = '0;
        data_o  = beat_data[gnt_q];
        if (state_q == LOCK) begin
            valid_o        = sel_valid;
            last_o         = pkt_end;
            ready_o[gnt_q] = ready_i;
        end
    end

    assign grant_id_o = gnt_q;
    assign busy_o     = (state_q == LOCK);
    assign trunc_o    = trunc_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: per-requester beat queues drive the inputs, a
// packet-level reference model predicts every output each cycle, and tagged
// beats ({requester, sequence}) check ordering and completeness downstream.
module tb_fifo_rr_arbiter;

    localparam int W  = 8;
    localparam int NR = 4;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             reset_i;
    logic [NR-1:0]    valid_i, last_i, ready_o;
    logic [NR*W-1:0]  data_i;
    logic             valid_o, last_o, ready_i, busy_o, trunc_o;
    logic [W-1:0]     data_o;
    logic [1:0]       grant_id_o;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.width_p(W), .num_req_p(NR), .max_beats_p(MB)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .last_i     (last_i),
        .ready_o    (ready_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .last_o     (last_o),
        .ready_i    (ready_i),
        .grant_id_o (grant_id_o),
        .busy_o     (busy_o),
        .trunc_o    (trunc_o)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
    } beat_t;

    beat_t pq [NR][$];
    int    seq_tx [NR];
    int    seq_rx [NR];

    // Reference model: who owns the fifo, beats sent in this packet, last winner.
    int    owner, gid, lastw, nb;
    bit    mtrunc, just_gnt;
    bit    waiting [NR];
    int    waitc [NR];
    int    gq [$];
    bit    bubble_en, auto_fill, rdy_rand;
    int    n_chk, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] tag_of(input int r, input int s);
        return W'((r << 6) | (s & 63));
    endfunction

    task automatic enq(input int r, input int len, input bit lastf);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.d = tag_of(r, seq_tx[r]);
            b.l = lastf && (i == len - 1);
            seq_tx[r]++;
            pq[r].push_back(b);
        end
    endtask

    task automatic model_reset();
        owner = -1; gid = 0; lastw = NR - 1; nb = 0; mtrunc = 0; just_gnt = 0;
        for (int r = 0; r < NR; r++) begin
            waiting[r] = 0;
            waitc[r]   = 0;
        end
    endtask

    // Producers hold their head beat until accepted; only the owner may bubble.
    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if (auto_fill && pq[r].size() == 0 && $urandom_range(0, 5) == 0)
                enq(r, $urandom_range(1, 20), 1'b1);
            if (pq[r].size() > 0) begin
                valid_i[r]          = !(bubble_en && r == owner && $urandom_range(0, 3) == 0);
                data_i[r*W +: W]    = pq[r][0].d;
                last_i[r]           = pq[r][0].l;
            end else begin
                valid_i[r]          = 1'b0;
                data_i[r*W +: W]    = '0;
                last_i[r]           = 1'b0;
            end
        end
        if (rdy_rand) ready_i = ($urandom_range(0, 9) < 7);
    endtask

    task automatic step();
        logic [NR-1:0] e_rdy;
        int  g;
        bit  lb;
        @(negedge clk);
        if (just_gnt) begin
            gq.push_back(int'(grant_id_o));
            just_gnt = 0;
        end
        e_rdy = '0;
        if (owner >= 0) e_rdy[owner] = ready_i;
        check("ready_o", 32'(ready_o), 32'(e_rdy));
        check("ready_onehot", 32'($onehot0(ready_o)), 32'd1);
        check("busy_o", 32'(busy_o), 32'(owner >= 0));
        check("grant_id_o", 32'(grant_id_o), gid);
        check("trunc_o", 32'(trunc_o), 32'(mtrunc));
        if (owner < 0) begin
            check("valid_o_idle", 32'(valid_o), 32'd0);
            check("last_o_idle", 32'(last_o), 32'd0);
        end else begin
            g = owner;
            check("valid_o", 32'(valid_o), 32'(valid_i[g]));
            check("last_o", 32'(last_o),
                  32'((pq[g].size() > 0 && pq[g][0].l) || nb == MB - 1));
            if (valid_i[g]) check("data_o", 32'(data_o), 32'(pq[g][0].d));
        end
        if (reset_i) begin
            model_reset();
        end else begin
            for (int r = 0; r < NR; r++)
                if (r != owner && valid_i[r] && !waiting[r]) begin
                    waiting[r] = 1;
                    waitc[r]   = 0;
                end
            if (owner < 0) begin
                for (int k = 1; k <= NR && owner < 0; k++) begin
                    int r;
                    r = (lastw + k) % NR;
                    if (valid_i[r]) owner = r;
                end
                if (owner >= 0) begin
                    check("fair", 32'(waitc[owner] <= NR - 1), 32'd1);
                    waiting[owner] = 0;
                    gid = owner; lastw = owner; nb = 0; just_gnt = 1;
                end
            end else if (valid_i[owner] && ready_i) begin
                g = owner;
                check("order", 32'(data_o), 32'(tag_of(g, seq_rx[g])));
                seq_rx[g]++;
                lb = pq[g][0].l || nb == MB - 1;
                if (nb == MB - 1 && !pq[g][0].l) mtrunc = 1;
                void'(pq[g].pop_front());
                if (lb) begin
                    owner = -1;
                    nb    = 0;
                    for (int r = 0; r < NR; r++)
                        if (r != g && waiting[r]) waitc[r]++;
                end else begin
                    nb++;
                end
            end
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    function automatic bit any_queued();
        for (int r = 0; r < NR; r++)
            if (pq[r].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int c;
        c = 0;
        bubble_en = 0; auto_fill = 0; rdy_rand = 0; ready_i = 1'b1;
        while (c < 3000 && (owner >= 0 || any_queued() || just_gnt)) begin
            step();
            c++;
        end
        check("drain_bound", 32'(c < 3000), 32'd1);
    endtask

    task automatic wait_grants(input int n, input int budget);
        int c;
        c = 0;
        while (gq.size() < n && c < budget) begin
            step();
            c++;
        end
        check("grant_count", gq.size(), n);
    endtask

    task automatic check_grants(input string tag, input int e0, input int e1,
                                input int e2, input int e3, input int e4, input int n);
        int exp [5];
        exp = '{e0, e1, e2, e3, e4};
        for (int i = 0; i < n && i < gq.size(); i++)
            check(tag, gq[i], exp[i]);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        gq.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_err = 0;
        bubble_en = 0; auto_fill = 0; rdy_rand = 0;
        for (int r = 0; r < NR; r++) begin
            seq_tx[r] = 0;
            seq_rx[r] = 0;
        end
        reset_i = 1'b1; ready_i = 1'b1;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_trunc", 32'(trunc_o), 32'd0);
        check("rst_gid", 32'(grant_id_o), 32'd0);
        @(posedge clk);
        #1;

        // All requesters valid with 1-beat packets: strict rotation from 0.
        gq.delete();
        for (int r = 0; r < NR; r++) begin
            enq(r, 1, 1'b1);
            enq(r, 1, 1'b1);
        end
        drive();
        wait_grants(5, 40);
        check_grants("t1_order", 0, 1, 2, 3, 0, 5);
        drain();

        // Multi-beat packet from 1 is not interleaved; 2 follows, then 0.
        do_reset();
        enq(1, 3, 1'b1);
        drive();
        step();
        enq(0, 2, 1'b1);
        enq(2, 2, 1'b1);
        drive();
        wait_grants(3, 60);
        check_grants("t2_order", 1, 2, 0, 0, 0, 3);
        drain();

        // Fifo full for 4 cycles mid-packet: beat stalls, outputs hold.
        do_reset();
        enq(0, 6, 1'b1);
        drive();
        repeat (3) step();
        ready_i = 1'b0;
        repeat (4) begin
            step();
            check("t3_stall_ready", 32'(ready_o), 32'd0);
            check("t3_stall_valid", 32'(valid_o), 32'd1);
        end
        ready_i = 1'b1;
        drain();

        // 20 beats from 3: cut at 16, remainder re-arbitrated after the others.
        do_reset();
        enq(3, 20, 1'b1);
        drive();
        repeat (3) step();
        for (int r = 0; r < 3; r++) enq(r, 2, 1'b1);
        drive();
        wait_grants(5, 200);
        check_grants("t4_order", 3, 0, 1, 2, 3, 5);
        drain();
        check("t4_trunc", 32'(trunc_o), 32'd1);

        // Reset on beat 2 of a packet from 2: back to IDLE, trunc cleared, 0 wins.
        gq.delete();
        enq(2, 5, 1'b1);
        drive();
        repeat (2) step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        enq(0, 1, 1'b1);
        drive();
        check("t5_busy", 32'(busy_o), 32'd0);
        check("t5_ready", 32'(ready_o), 32'd0);
        check("t5_trunc", 32'(trunc_o), 32'd0);
        gq.delete();
        wait_grants(1, 20);
        check_grants("t5_first", 0, 0, 0, 0, 0, 1);
        drain();

        // Random traffic with bubbles, backpressure and oversize packets.
        bubble_en = 1; auto_fill = 1; rdy_rand = 1;
        drive();
        repeat (10000) step();
        drain();
        for (int r = 0; r < NR; r++)
            check("complete", seq_rx[r], seq_tx[r]);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
